instrom_loader: RTL and testbench
=================================

Name: instrom_loader

Overview:
- Instruction-memory responder for the core's fetch port. It answers the core's `instrom_addr` / `instrom_ren` request with a synchronous-read instruction word one cycle later.
- Before execution it fills its storage from a byte-stream boot loader, using a valid/ready handshake.
- It sits beside the core in the SoC top. `boot_done` gates the core out of reset.

Parameters:
- DEPTH, 4096, number of 32-bit words stored; power of two.
- AW, 12, word-index width; equals log2(DEPTH).
- BASE_ADDR, 32'h8000_0000, byte address of word 0.
- NOP_INST, 32'h0000_0013, word returned while loading (addi x0,x0,0).
- ERR_INST, 32'h0000_0000, word returned for an out-of-range fetch (illegal instruction).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- instrom_addr  input  32  byte fetch address from the core.
- instrom_ren  input  1  fetch read enable from the core.
- instrom_data  output  32  fetched instruction, registered.
- load_valid  input  1  boot byte valid.
- load_data  input  8  boot byte.
- load_last  input  1  marks the final byte of the image; qualified by load_valid.
- load_ready  output  1  loader can accept a byte.
- boot_done  output  1  image loaded; core may run.
- fetch_err  output  1  sticky flag: an out-of-range fetch occurred in RUN.

Behaviour:
- Reset (rst=0, asynchronous) drives the block to:
  - state=LOAD, wr_ptr=0, byte_cnt=0, word_buf=0;
  - instrom_data=NOP_INST, boot_done=0, fetch_err=0, load_ready=0 while rst asserted.
  - The storage array is not reset; its contents survive reset.
- Two states:
  - LOAD: load_ready=1, boot_done=0.
  - RUN: load_ready=0, boot_done=1.
  - LOAD->RUN on either termination event below.
  - No RUN->LOAD transition except by reset.
- Load transfer:
  - A byte transfers in a cycle with load_valid=1 and load_ready=1.
  - Bytes pack little-endian: byte_cnt k (0..3) goes to word_buf[8k+7:8k].
  - On the transfer with byte_cnt=3, the assembled word is written to mem[wr_ptr]; wr_ptr then increments and byte_cnt returns to 0.
  - If load_last is transferred with byte_cnt<3, the word is written with the remaining upper bytes zero.
- Load termination:
  - Completed when load_last is transferred, or when the word written to index DEPTH-1 completes (wr_ptr would wrap).
  - Transition to RUN happens on that same edge; boot_done=1 from the next cycle.
  - Bytes presented after termination are not accepted (load_ready=0) and memory is unchanged.
  - wr_ptr never wraps to overwrite word 0.
- Fetch, 1-cycle latency:
  - On a rising edge with instrom_ren=1, instrom_data updates; with instrom_ren=0 it holds its value.
  - Word index: off = instrom_addr - BASE_ADDR, index = off[AW+1:2]. off[1:0] is ignored (no misalign fault here).
  - In range means instrom_addr >= BASE_ADDR and off < 4*DEPTH.
  - LOAD state: always returns NOP_INST, regardless of address.
  - RUN, in range: returns mem[index].
  - RUN, out of range: returns ERR_INST and sets fetch_err=1 on the same edge; fetch_err stays set until reset.
- Simultaneous events:
  - A write and a fetch cannot collide on data, since fetches return NOP_INST in LOAD.
  - A fetch on the same edge as LOAD->RUN still returns NOP_INST; fetches return memory from the following edge.
- Reset mid-load: the partial word is discarded and loading restarts at word 0 on the first byte after reset release.
- Storage must map to a single-port-write, single-port-read synchronous RAM; there is no combinational read path.

Test Plan:
- Reset release, then 8 bytes 13 00 00 00 93 00 10 00 with last on byte 8, then RUN fetch of 0x80000000 and 0x80000004 -> boot_done=1, instrom_data=0x00000013 then 0x00100093, each one cycle after ren.
- 5 bytes AA BB CC DD 11 with last on byte 5 -> mem[1]=0x00000011, RUN entered on the 5th transfer edge, load_ready=0 thereafter, a 6th byte is ignored.
- Fetch of 0x80000000 with ren=1 during LOAD -> 0x00000013; ren toggled 1,0,0 in RUN -> instrom_data holds its value during the ren=0 cycles.
- RUN fetch of 0x7FFFFFFC, then 0x80004000 (DEPTH=4096) -> instrom_data=0x00000000, fetch_err=1, sticky across later valid fetches.
- DEPTH=4 instance, 20 bytes streamed with no load_last -> RUN after byte 16, mem[0] not overwritten, bytes 17-20 stall with load_ready=0.
- rst pulsed low after 6 bytes, then 4 bytes 01 02 03 04 with last -> mem[0]=0x04030201, mem[1] unchanged from the pre-reset write attempt, all outputs at reset values during the pulse.

Source files
------------

// File: rtl/instrom_loader.sv
// Instruction ROM for the core's fetch port. It is filled from a little-endian boot byte
// stream, then serves registered fetches from a single-write/single-read synchronous RAM.
module instrom_loader #(
    parameter int unsigned DEPTH     = 4096,
    parameter int unsigned AW        = 12,
    parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
    parameter logic [31:0] NOP_INST  = 32'h0000_0013,
    parameter logic [31:0] ERR_INST  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instrom_addr,
    input  logic        instrom_ren,
    output logic [31:0] instrom_data,
    input  logic        load_valid,
    input  logic [7:0]  load_data,
    input  logic        load_last,
    output logic        load_ready,
    output logic        boot_done,
    output logic        fetch_err
);

    typedef enum logic {ST_LOAD, ST_RUN} state_t;
    typedef enum logic [1:0] {SEL_NOP, SEL_ERR, SEL_MEM} sel_t;

    localparam logic [32:0] SPAN     = 33'(4 * DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    state_t        state_q, state_d;
    sel_t          sel_q, sel_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [31:0]   word_buf_q, word_buf_d;
    logic          fetch_err_q, fetch_err_d;

    logic [31:0]   mem [DEPTH];
    logic [31:0]   rd_word_q;
    logic          mem_we;
    logic [31:0]   word_merged;
    logic [31:0]   off;
    logic          in_range;
    logic [AW-1:0] rd_idx;
    logic          load_fire;

    assign off      = instrom_addr - BASE_ADDR;
    assign in_range = (instrom_addr >= BASE_ADDR) && ({1'b0, off} < SPAN);
    assign rd_idx   = off[AW+1:2];

    // Ready is also forced low while reset is held, not just once the state flop clears.
    assign load_ready = rst && (state_q == ST_LOAD);
    assign boot_done  = (state_q == ST_RUN);
    assign fetch_err  = fetch_err_q;
    assign load_fire  = load_valid && load_ready;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        wr_ptr_d    = wr_ptr_q;
        byte_cnt_d  = byte_cnt_q;
        word_buf_d  = word_buf_q;
        fetch_err_d = fetch_err_q;
        mem_we      = 1'b0;
        word_merged = word_buf_q;
        word_merged[{byte_cnt_q, 3'b000} +: 8] = load_data;

        if (load_fire) begin
            if (byte_cnt_q == 2'd3 || load_last) begin
                // word_buf is cleared after every write, so a short final word is zero-padded
                mem_we     = 1'b1;
                word_buf_d = '0;
                byte_cnt_d = '0;
                if (load_last || wr_ptr_q == LAST_IDX) begin
                    state_d = ST_RUN;
                end else begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
            end else begin
                word_buf_d = word_merged;
                byte_cnt_d = byte_cnt_q + 2'd1;
            end
        end

        // Uses the current state, so a fetch on the LOAD->RUN edge still yields a NOP
        if (instrom_ren) begin
            if (state_q == ST_LOAD) begin
                sel_d = SEL_NOP;
            end else if (in_range) begin
                sel_d = SEL_MEM;
            end else begin
                sel_d       = SEL_ERR;
                fetch_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_LOAD;
            sel_q       <= SEL_NOP;
            wr_ptr_q    <= '0;
            byte_cnt_q  <= '0;
            word_buf_q  <= '0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            wr_ptr_q    <= wr_ptr_d;
            byte_cnt_q  <= byte_cnt_d;
            word_buf_q  <= word_buf_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    // Storage and its read register carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= word_merged;
        end
        if (instrom_ren) begin
            rd_word_q <= mem[rd_idx];
        end
    end

    always_comb begin
        instrom_data = NOP_INST;
        case (sel_q)
            SEL_MEM: instrom_data = rd_word_q;
            SEL_ERR: instrom_data = ERR_INST;
            default: instrom_data = NOP_INST;
        endcase
    end

endmodule

// File: tb/tb_instrom_loader.sv
// Directed bench for instrom_loader: a default-depth instance plus a DEPTH=4 instance
// for the fill-to-capacity case.
module tb_instrom_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, ren, valid, last;
    logic [31:0] addr, data_o;
    logic [7:0]  data;
    logic        ready, done, err;

    logic        s_rst, s_ren, s_valid, s_last;
    logic [31:0] s_addr, s_data_o;
    logic [7:0]  s_data;
    logic        s_ready, s_done, s_err;

    int checks = 0;
    int errors = 0;

    instrom_loader u_dut (
        .clk(clk), .rst(rst), .instrom_addr(addr), .instrom_ren(ren), .instrom_data(data_o),
        .load_valid(valid), .load_data(data), .load_last(last), .load_ready(ready),
        .boot_done(done), .fetch_err(err)
    );

    instrom_loader #(.DEPTH(4), .AW(2)) u_small (
        .clk(clk), .rst(s_rst), .instrom_addr(s_addr), .instrom_ren(s_ren), .instrom_data(s_data_o),
        .load_valid(s_valid), .load_data(s_data), .load_last(s_last), .load_ready(s_ready),
        .boot_done(s_done), .fetch_err(s_err)
    );

    task automatic send_byte(input logic [7:0] b, input logic l);
        @(negedge clk);
        valid = 1'b1; data = b; last = l;
        @(posedge clk);
        #1 valid = 1'b0; last = 1'b0;
        $display("byte %h last=%0b ready=%0b done=%0b", b, l, ready, done);
    endtask

    task automatic fetch(input logic [31:0] a);
        @(negedge clk);
        addr = a; ren = 1'b1;
        @(posedge clk);
        #1 ren = 1'b0;
        $display("fetch %h -> %h err=%0b", a, data_o, err);
    endtask

    task automatic s_send_byte(input logic [7:0] b, input logic l);
        @(negedge clk);
        s_valid = 1'b1; s_data = b; s_last = l;
        @(posedge clk);
        #1 s_valid = 1'b0; s_last = 1'b0;
        $display("small byte %h ready=%0b done=%0b", b, s_ready, s_done);
    endtask

    task automatic s_fetch(input logic [31:0] a);
        @(negedge clk);
        s_addr = a; s_ren = 1'b1;
        @(posedge clk);
        #1 s_ren = 1'b0;
        $display("small fetch %h -> %h err=%0b", a, s_data_o, s_err);
    endtask

    task automatic test_reset;
        #2;
        checks++; if (data_o !== 32'h13) begin errors++; $display("FAIL reset_data got %h exp %h", data_o, 32'h13); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready); end
        @(negedge clk);
        rst = 1'b1; s_rst = 1'b1;
        #1;
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL release_ready got %b exp 1", ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL release_done got %b exp 0", done); end
    endtask

    task automatic test_load_fetch;
        fetch(32'h0000_0000);
        checks++; if (data_o !== 32'h13) begin errors++; $display("FAIL load_fetch_nop got %h exp %h", data_o, 32'h13); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL load_fetch_err got %b exp 0", err); end
        send_byte(8'h13, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
        send_byte(8'h93, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h10, 1'b0);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL pre_last_done got %b exp 0", done); end
        // final byte and a fetch on the same edge
        @(negedge clk);
        valid = 1'b1; data = 8'h00; last = 1'b1; addr = 32'h8000_0004; ren = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0; last = 1'b0; ren = 1'b0;
        $display("last byte + fetch -> %h done=%0b ready=%0b", data_o, done, ready);
        checks++; if (data_o !== 32'h13) begin errors++; $display("FAIL edge_fetch got %h exp %h", data_o, 32'h13); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL run_done got %b exp 1", done); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL run_ready got %b exp 0", ready); end
        fetch(32'h8000_0000);
        checks++; if (data_o !== 32'h0000_0013) begin errors++; $display("FAIL run_fetch0 got %h exp %h", data_o, 32'h13); end
        fetch(32'h8000_0004);
        checks++; if (data_o !== 32'h0010_0093) begin errors++; $display("FAIL run_fetch4 got %h exp %h", data_o, 32'h0010_0093); end
        @(negedge clk);
        addr = 32'h8000_0000; ren = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            $display("hold cycle %0d -> %h", i, data_o);
            checks++; if (data_o !== 32'h0010_0093) begin errors++; $display("FAIL hold_%0d got %h exp %h", i, data_o, 32'h0010_0093); end
        end
    endtask

    task automatic test_fetch_err;
        fetch(32'h8000_3FFC);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL top_word_err got %b exp 0", err); end
        fetch(32'h7FFF_FFFC);
        checks++; if (data_o !== 32'h0) begin errors++; $display("FAIL below_base_data got %h exp 0", data_o); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL below_base_err got %b exp 1", err); end
        fetch(32'h8000_0004);
        checks++; if (data_o !== 32'h0010_0093) begin errors++; $display("FAIL after_err_data got %h exp %h", data_o, 32'h0010_0093); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL sticky_err got %b exp 1", err); end
        fetch(32'h8000_4000);
        checks++; if (data_o !== 32'h0) begin errors++; $display("FAIL above_top_data got %h exp 0", data_o); end
    endtask

    task automatic test_partial_last;
        @(negedge clk); rst = 1'b0;
        @(negedge clk); rst = 1'b1;
        send_byte(8'hAA, 1'b0); send_byte(8'hBB, 1'b0); send_byte(8'hCC, 1'b0); send_byte(8'hDD, 1'b0);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL partial_ready4 got %b exp 1", ready); end
        send_byte(8'h11, 1'b1);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL partial_done got %b exp 1", done); end
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL partial_ready5 got %b exp 0", ready); end
        send_byte(8'hEE, 1'b0);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL extra_ready got %b exp 0", ready); end
        fetch(32'h8000_0000);
        checks++; if (data_o !== 32'hDDCC_BBAA) begin errors++; $display("FAIL partial_w0 got %h exp %h", data_o, 32'hDDCC_BBAA); end
        fetch(32'h8000_0004);
        checks++; if (data_o !== 32'h0000_0011) begin errors++; $display("FAIL partial_w1 got %h exp %h", data_o, 32'h11); end
        fetch(32'h9000_0000);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL partial_oor_err got %b exp 1", err); end
    endtask

    task automatic test_reset_midload;
        @(negedge clk); rst = 1'b0;
        #1;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_clears_err got %b exp 0", err); end
        checks++; if (data_o !== 32'h13) begin errors++; $display("FAIL rst_data got %h exp %h", data_o, 32'h13); end
        @(negedge clk); rst = 1'b1;
        send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0); send_byte(8'h55, 1'b0); send_byte(8'h66, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        $display("mid-load reset: data=%h ready=%0b done=%0b err=%0b", data_o, ready, done, err);
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL midrst_ready got %b exp 0", ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b exp 0", done); end
        checks++; if (data_o !== 32'h13) begin errors++; $display("FAIL midrst_data got %h exp %h", data_o, 32'h13); end
        @(negedge clk); rst = 1'b1;
        send_byte(8'h01, 1'b0); send_byte(8'h02, 1'b0); send_byte(8'h03, 1'b0); send_byte(8'h04, 1'b1);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL reload_done got %b exp 1", done); end
        fetch(32'h8000_0000);
        checks++; if (data_o !== 32'h0403_0201) begin errors++; $display("FAIL reload_w0 got %h exp %h", data_o, 32'h0403_0201); end
        fetch(32'h8000_0004);
        checks++; if (data_o !== 32'h0000_0011) begin errors++; $display("FAIL reload_w1 got %h exp %h", data_o, 32'h11); end
    endtask

    task automatic test_depth_limit;
        for (int i = 1; i <= 15; i++) s_send_byte(8'(i), 1'b0);
        checks++; if (s_ready !== 1'b1 || s_done !== 1'b0) begin errors++; $display("FAIL small_pre16 got ready=%b done=%b exp ready=1 done=0", s_ready, s_done); end
        s_send_byte(8'd16, 1'b0);
        checks++; if (s_done !== 1'b1) begin errors++; $display("FAIL small_done got %b exp 1", s_done); end
        for (int i = 17; i <= 20; i++) begin
            s_send_byte(8'(i), 1'b0);
            checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL small_stall_%0d got %b exp 0", i, s_ready); end
        end
        s_fetch(32'h8000_0000);
        checks++; if (s_data_o !== 32'h0403_0201) begin errors++; $display("FAIL small_w0 got %h exp %h", s_data_o, 32'h0403_0201); end
        s_fetch(32'h8000_000C);
        checks++; if (s_data_o !== 32'h100F_0E0D) begin errors++; $display("FAIL small_w3 got %h exp %h", s_data_o, 32'h100F_0E0D); end
        s_fetch(32'h8000_0010);
        checks++; if (s_data_o !== 32'h0 || s_err !== 1'b1) begin errors++; $display("FAIL small_oor got data=%h err=%b exp data=0 err=1", s_data_o, s_err); end
        s_fetch(32'h8000_0004);
        checks++; if (s_data_o !== 32'h0807_0605) begin errors++; $display("FAIL small_w1 got %h exp %h", s_data_o, 32'h0807_0605); end
    endtask

    initial begin
        rst = 1'b0; ren = 1'b0; valid = 1'b0; last = 1'b0; addr = '0; data = '0;
        s_rst = 1'b0; s_ren = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_addr = '0; s_data = '0;
        test_reset;
        test_load_fetch;
        test_fetch_err;
        test_partial_last;
        test_reset_midload;
        test_depth_limit;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
